// File: rtl/grid_io_cfg_array.sv
// Parametrised GPIO boundary tile: a serial configuration chain loads per-subtile
// mode words into a shadow register, and an accepted commit applies them to the pads.
module grid_io_cfg_array #(
    parameter int NUM_SUBTILES = 8,
    parameter int CFG_BITS     = 4,
    localparam int TOTAL_BITS  = NUM_SUBTILES * CFG_BITS,
    localparam int CW          = $clog2(TOTAL_BITS + 1)
) (
    input  logic                    prog_clk,
    input  logic                    prog_reset_n,
    inout  wire  [0:NUM_SUBTILES-1] gfpga_pad_GPIO_PAD,
    input  logic [NUM_SUBTILES-1:0] io_outpad,
    output logic [NUM_SUBTILES-1:0] io_inpad,
    input  logic                    ccff_head,
    input  logic                    ccff_en,
    input  logic                    cfg_commit,
    output logic                    ccff_tail,
    output logic [CW-1:0]           cfg_count,
    output logic                    cfg_ready,
    output logic                    cfg_active,
    output logic                    cfg_err
);

    if (CFG_BITS != 4) begin : g_bad_cfg_bits
        $error("grid_io_cfg_array: CFG_BITS must be 4");
    end
    if (NUM_SUBTILES < 1 || NUM_SUBTILES > 64) begin : g_bad_num_subtiles
        $error("grid_io_cfg_array: NUM_SUBTILES must be within 1..64");
    end

    localparam logic [CW-1:0] COUNT_MAX  = '1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(TOTAL_BITS);

    typedef struct packed {
        logic inv;
        logic out_reg;
        logic in_reg;
        logic oe;
    } mode_t;

    // Reset asserts immediately but releases only after two prog_clk edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic [0:TOTAL_BITS-1] chain_q;
    logic [0:TOTAL_BITS-1] active_q;
    logic                  commit_ok;
    logic [CW-1:0]         count_nxt;

    assign cfg_ready = (cfg_count == COUNT_FULL);
    assign commit_ok = cfg_commit && cfg_ready;
    assign ccff_tail = chain_q[TOTAL_BITS-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge prog_clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else if (ccff_en) begin
            chain_q <= {ccff_head, chain_q[0:TOTAL_BITS-2]};
        end
    end

    // NOTE: both config stores are ordinary flops rather than a RAM, so they take
    // the async reset and a partial load is cleared along with everything else.
    always_ff @(posedge prog_clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
        end else if (commit_ok) begin
            active_q <= chain_q;
        end
    end

    // NOTE: count_nxt gets its hold value first so no path through this block can
    // leave it unassigned and infer a latch.
    always_comb begin
        count_nxt = cfg_count;
        if (ccff_en && cfg_count != COUNT_MAX) begin
            count_nxt = cfg_count + 1'b1;
        end
        if (commit_ok) begin
            count_nxt = '0;
        end
    end

    always_ff @(posedge prog_clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_count  <= '0;
            cfg_active <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_count <= count_nxt;
            if (commit_ok) begin
                cfg_active <= 1'b1;
            end
            if (cfg_commit && !cfg_ready) begin
                cfg_err <= 1'b1;
            end
        end
    end

    mode_t mode [NUM_SUBTILES];

    always_comb begin
        mode = '{default: '0};
        for (int k = 0; k < NUM_SUBTILES; k++) begin
            mode[k].oe      = active_q[CFG_BITS*k + 0];
            mode[k].in_reg  = active_q[CFG_BITS*k + 1];
            mode[k].out_reg = active_q[CFG_BITS*k + 2];
            mode[k].inv     = active_q[CFG_BITS*k + 3];
        end
    end

    wire  [NUM_SUBTILES-1:0] pad_in;
    logic [NUM_SUBTILES-1:0] pad_q;
    logic [NUM_SUBTILES-1:0] outpad_q;

    always_ff @(posedge prog_clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_q    <= '0;
            outpad_q <= '0;
        end else begin
            pad_q    <= pad_in;
            outpad_q <= io_outpad;
        end
    end

    for (genvar k = 0; k < NUM_SUBTILES; k++) begin : g_sub
        logic src;

        assign pad_in[k] = gfpga_pad_GPIO_PAD[k];
        assign src       = mode[k].out_reg ? outpad_q[k] : io_outpad[k];
        assign gfpga_pad_GPIO_PAD[k] = mode[k].oe ? (src ^ mode[k].inv) : 1'bz;
    end

    // A pad in output mode never echoes its own drive back into the fabric.
    always_comb begin
        io_inpad = '0;
        for (int k = 0; k < NUM_SUBTILES; k++) begin
            if (!mode[k].oe) begin
                io_inpad[k] = (mode[k].in_reg ? pad_q[k] : pad_in[k]) ^ mode[k].inv;
            end
        end
    end

endmodule

// File: tb/tb_grid_io_cfg_array.sv
// Directed bench for grid_io_cfg_array (8 subtiles): pads are pulled up so an
// undriven pad reads 1, while a pad driven by the tile can be seen pulling it to 0.
module tb_grid_io_cfg_array;

    localparam int N  = 8;
    localparam int TB = 32;
    localparam int CW = 6;

    logic          prog_clk;
    logic          prog_reset_n;
    tri1  [0:N-1]  pads;
    logic [N-1:0]  io_outpad;
    logic [N-1:0]  io_inpad;
    logic          ccff_head;
    logic          ccff_en;
    logic          cfg_commit;
    logic          ccff_tail;
    logic [CW-1:0] cfg_count;
    logic          cfg_ready;
    logic          cfg_active;
    logic          cfg_err;
    logic [0:N-1]  drv_en;
    logic [0:N-1]  drv_val;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];

    for (genvar k = 0; k < N; k++) begin : g_drv
        assign pads[k] = drv_en[k] ? drv_val[k] : 1'bz;
    end

    grid_io_cfg_array #(.NUM_SUBTILES(N)) dut (
        .prog_clk          (prog_clk),
        .prog_reset_n      (prog_reset_n),
        .gfpga_pad_GPIO_PAD(pads),
        .io_outpad         (io_outpad),
        .io_inpad          (io_inpad),
        .ccff_head         (ccff_head),
        .ccff_en           (ccff_en),
        .cfg_commit        (cfg_commit),
        .ccff_tail         (ccff_tail),
        .cfg_count         (cfg_count),
        .cfg_ready         (cfg_ready),
        .cfg_active        (cfg_active),
        .cfg_err           (cfg_err)
    );

    initial begin
        prog_clk = 1'b0;
        forever #5 prog_clk = ~prog_clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    function automatic logic [0:TB-1] mk(input int k, input logic [3:0] m);
        logic [0:TB-1] v;
        v = '0;
        for (int b = 0; b < 4; b++) v[4*k + b] = m[b];
        return v;
    endfunction

    // The bit for chain[i] is shifted at step TB-1-i, so it lands at index i.
    task automatic shift_bits(input logic [0:TB-1] v, input int lo, input int hi);
        for (int j = lo; j <= hi; j++) begin
            ccff_en   = 1'b1;
            ccff_head = v[TB-1-j];
            tick();
        end
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic do_reset();
        prog_reset_n = 1'b0;
        tick();
        prog_reset_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        logic [0:TB-1] cfg_v;
        logic          pat;
        logic          last_tail;

        prog_reset_n = 1'b0;
        io_outpad    = '0;
        ccff_head    = 1'b0;
        ccff_en      = 1'b0;
        cfg_commit   = 1'b0;
        drv_en       = '0;
        drv_val      = '0;
        last_tail    = 1'b0;
        repeat (3) @(posedge prog_clk);
        #1;
        prog_reset_n = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_pads_z", pads, 8'hFF);
        check("rst_inpad", io_inpad, 8'hFF);
        check("rst_count", cfg_count, 0);
        check("rst_err", cfg_err, 0);
        check("rst_active", cfg_active, 0);
        check("rst_ready", cfg_ready, 0);
        check("rst_tail", ccff_tail, 0);
        drv_en[3]  = 1'b1;
        drv_val[3] = 1'b0;
        #1 check("rst_inpad3_lo", io_inpad[3], 0);
        drv_val[3] = 1'b1;
        #1 check("rst_inpad3_hi", io_inpad[3], 1);
        drv_en[3]  = 1'b0;

        // Subtile 0 output-only, unregistered
        shift_bits(mk(0, 4'b0001), 0, TB - 1);
        check("oe_ready", cfg_ready, 1);
        check("oe_count_full", cfg_count, 32);
        commit();
        check("oe_active", cfg_active, 1);
        check("oe_count_clr", cfg_count, 0);
        io_outpad[0] = 1'b1;
        push_exp("oe_pad0_hi", 1);
        push_exp("oe_inpad0", 0);
        #1 pop_check(pads[0]);
        pop_check(io_inpad[0]);
        io_outpad[0] = 1'b0;
        push_exp("oe_pad0_lo", 0);
        #1 pop_check(pads[0]);

        // Early commit after 31 shifts is rejected
        cfg_v = mk(2, 4'b1010);
        shift_bits(cfg_v, 0, TB - 2);
        check("early_count31", cfg_count, 31);
        commit();
        check("early_err", cfg_err, 1);
        check("early_count_kept", cfg_count, 31);
        check("early_pad0_still_driven", pads[0], 0);
        drv_en[2]  = 1'b1;
        drv_val[2] = 1'b1;
        #1 check("early_inpad2_old_cfg", io_inpad[2], 1);
        shift_bits(cfg_v, TB - 1, TB - 1);
        commit();
        check("late_count_clr", cfg_count, 0);
        check("late_err_sticky", cfg_err, 1);
        check("late_pad0_z", pads[0], 1);

        // Subtile 2 IN_REG + INV: one cycle of latency, inverted
        drv_val[2] = 1'b0;
        repeat (2) tick();
        drv_val[2] = 1'b1;
        push_exp("inreg_cycle_n", 1);
        push_exp("inreg_cycle_n1", 0);
        #1 pop_check(io_inpad[2]);
        tick();
        pop_check(io_inpad[2]);
        drv_en = '0;

        // Chain passthrough: tail replays the input 32 shifts later
        for (int j = 0; j < 40; j++) begin
            pat       = (j % 4 == 0) || (j % 4 == 3);
            ccff_en   = 1'b1;
            ccff_head = pat;
            push_exp($sformatf("tail_s%0d", j + 1), pat);
            tick();
            if (j + 1 >= TB) begin
                last_tail = sb[0].val[0];
                pop_check(ccff_tail);
            end
        end
        ccff_en = 1'b0;
        sb.delete();
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("tail_hold_%0d", c), ccff_tail, last_tail);
        end
        check("count_40", cfg_count, 40);
        check("ready_40", cfg_ready, 0);
        shift_bits('0, 0, 29);
        check("count_saturate", cfg_count, 63);

        // Commit and shift in the same cycle: pre-shift chain wins, count clears
        do_reset();
        check("rst2_count", cfg_count, 0);
        shift_bits(mk(1, 4'b0001), 0, TB - 1);
        cfg_commit = 1'b1;
        ccff_en    = 1'b1;
        ccff_head  = 1'b1;
        tick();
        cfg_commit = 1'b0;
        ccff_en    = 1'b0;
        ccff_head  = 1'b0;
        check("cs_count_zero", cfg_count, 0);
        check("cs_active", cfg_active, 1);
        check("cs_pad1_driven", pads[1], 0);
        check("cs_pad0_z", pads[0], 1);

        // Reset in the middle of a load
        shift_bits('1, 0, 16);
        check("mid_count17", cfg_count, 17);
        prog_reset_n = 1'b0;
        #1;
        check("mid_rst_count", cfg_count, 0);
        check("mid_rst_pad1_z", pads[1], 1);
        check("mid_rst_active", cfg_active, 0);
        check("mid_rst_tail", ccff_tail, 0);
        tick();
        prog_reset_n = 1'b1;
        repeat (3) tick();
        check("post_rst_pads_z", pads, 8'hFF);
        check("post_rst_count", cfg_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
